// File: rtl/clk_enable_gen_prog.sv
// clk_enable_gen_prog: programmable sample/symbol clock-enable generator for
//   the modem datapath. Produces registered single-clk sam_clk_ena and
//   sym_clk_ena pulses, plus sam_idx (position of the sample within the symbol).
// Ports: clk/reset (async, active-high); sam_div/sym_div/cfg_load load a
//   shadow ratio that is applied on the next symbol wrap (cfg_pending shows it
//   is waiting); phase_adv/phase_ret nudge the sample grid by one clk.
// Optional feature macro: CLK_ENA_PHASE_ADJ_EN enables the phase nudges; when
//   it is undefined the phase ports are ignored and the counters free-run.
module clk_enable_gen_prog #(
    parameter int SAM_DIV_W   = 4,
    parameter int SYM_DIV_W   = 4,
    parameter int SAM_DIV_DEF = 3,
    parameter int SYM_DIV_DEF = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SAM_DIV_W-1:0] sam_div,
    input  logic [SYM_DIV_W-1:0] sym_div,
    input  logic                 cfg_load,
    output logic                 cfg_pending,
    input  logic                 phase_adv,
    input  logic                 phase_ret,
    output logic                 sam_clk_ena,
    output logic                 sym_clk_ena,
    output logic [SYM_DIV_W-1:0] sam_idx
);

    localparam logic [SAM_DIV_W-1:0] SAM_ONE  = SAM_DIV_W'(1);
    localparam logic [SYM_DIV_W-1:0] SYM_ONE  = SYM_DIV_W'(1);

    logic [SAM_DIV_W-1:0] sam_cnt;
    logic [SAM_DIV_W-1:0] sam_cnt_nxt;
    logic [SAM_DIV_W-1:0] sam_div_r;
    logic [SAM_DIV_W-1:0] sam_div_sh;
    logic [SYM_DIV_W-1:0] sym_cnt;
    logic [SYM_DIV_W-1:0] sym_div_r;
    logic [SYM_DIV_W-1:0] sym_div_sh;
    logic                 pend;
    logic                 sam_wrap;
    logic                 sym_wrap;

`ifdef CLK_ENA_PHASE_ADJ_EN
    logic adj_used;
    logic req_adv;
    logic req_ret;
    logic adj_acc;

    // Simultaneous advance and retard cancel out; one nudge per sample period.
    assign req_adv = phase_adv & ~phase_ret & ~adj_used;
    assign req_ret = phase_ret & ~phase_adv & ~adj_used;

    always_comb begin
        sam_wrap    = 1'b0;
        sam_cnt_nxt = sam_cnt + SAM_ONE;
        adj_acc     = 1'b0;
        if (sam_div_r == '0) begin
            // Every edge is a wrap here; advance has nothing to shorten,
            // while retard swallows one pulse.
            if (req_ret) begin
                sam_cnt_nxt = sam_cnt;
                adj_acc     = 1'b1;
            end else begin
                sam_wrap    = 1'b1;
                sam_cnt_nxt = '0;
            end
        end else if (req_ret) begin
            sam_cnt_nxt = sam_cnt;
            adj_acc     = 1'b1;
        end else if (req_adv) begin
            adj_acc = 1'b1;
            // Skipping past the terminal count means the period ends now.
            if (sam_cnt >= sam_div_r - SAM_ONE) begin
                sam_wrap    = 1'b1;
                sam_cnt_nxt = '0;
            end else begin
                sam_cnt_nxt = sam_cnt + SAM_DIV_W'(2);
            end
        end else if (sam_cnt == sam_div_r) begin
            sam_wrap    = 1'b1;
            sam_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adj_used <= 1'b0;
        end else if (sam_wrap) begin
            adj_used <= 1'b0;
        end else if (adj_acc) begin
            adj_used <= 1'b1;
        end
    end
`else
    logic unused_phase;
    assign unused_phase = phase_adv | phase_ret;

    always_comb begin
        sam_wrap    = (sam_cnt == sam_div_r);
        sam_cnt_nxt = sam_wrap ? '0 : sam_cnt + SAM_ONE;
    end
`endif

    assign sym_wrap = sam_wrap && (sym_cnt == sym_div_r);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sam_cnt     <= '0;
            sym_cnt     <= '0;
            sam_div_r   <= SAM_DIV_W'(SAM_DIV_DEF);
            sym_div_r   <= SYM_DIV_W'(SYM_DIV_DEF);
            sam_div_sh  <= '0;
            sym_div_sh  <= '0;
            pend        <= 1'b0;
            sam_clk_ena <= 1'b0;
            sym_clk_ena <= 1'b0;
        end else begin
            sam_cnt     <= sam_cnt_nxt;
            sam_clk_ena <= sam_wrap;
            sym_clk_ena <= sym_wrap;
            if (sam_wrap) begin
                sym_cnt <= sym_wrap ? '0 : sym_cnt + SYM_ONE;
            end
            // A pending ratio only ever switches in at a symbol boundary, so
            // both counters restart from 0 under the new divisors.
            if (sym_wrap && pend) begin
                sam_div_r <= sam_div_sh;
                sym_div_r <= sym_div_sh;
            end
            // A load on the wrap edge itself waits for the following wrap.
            if (cfg_load) begin
                sam_div_sh <= sam_div;
                sym_div_sh <= sym_div;
                pend       <= 1'b1;
            end else if (sym_wrap) begin
                pend <= 1'b0;
            end
        end
    end

    assign sam_idx     = sym_cnt;
    assign cfg_pending = pend;

endmodule

// File: doc/clk_enable_gen_prog.md
# clk_enable_gen_prog

Programmable clock-enable generator for the DSP modem datapath. It produces single-cycle sample and symbol enables from one system clock, with run-time ratios and a per-sample index. Ratio changes take effect only on symbol boundaries. Optional one-clock phase nudges let the timing-recovery loop slide the sample grid. All modem stages downstream of the clock run on these enables rather than on derived clocks.

## Interface
- SAM_DIV_W, 4: width of the clocks-per-sample field.
- SYM_DIV_W, 4: width of the samples-per-symbol field and of sam_idx.
- SAM_DIV_DEF, 3: reset value of the active sample divisor (clocks per sample − 1).
- SYM_DIV_DEF, 3: reset value of the active symbol divisor (samples per symbol − 1).

Ports (direction, width, meaning):
- clk, in, 1: system clock; the block's only clock.
- reset, in, 1: asynchronous, active-high reset.
- sam_div, in, SAM_DIV_W: requested clocks per sample − 1.
- sym_div, in, SYM_DIV_W: requested samples per symbol − 1.
- cfg_load, in, 1: one-cycle strobe that captures sam_div and sym_div into the shadow registers.
- cfg_pending, out, 1: shadow holds a value not yet applied.
- phase_adv, in, 1: request to shorten the current sample period by one clk.
- phase_ret, in, 1: request to lengthen the current sample period by one clk.
- sam_clk_ena, out, 1: registered one-clk sample enable.
- sym_clk_ena, out, 1: registered one-clk symbol enable; always coincides with a sam_clk_ena pulse.
- sam_idx, out, SYM_DIV_W: index of the current sample within the symbol; 0 while the symbol pulse is high.

## Operation
- Registers: sam_cnt, sym_cnt, sam_div_r, sym_div_r, shadow pair, pend flag, adj_used flag.
- Reset values:
  - sam_cnt = 0, sym_cnt = 0.
  - sam_div_r = SAM_DIV_DEF, sym_div_r = SYM_DIV_DEF.
  - cfg_pending = 0, sam_clk_ena = 0, sym_clk_ena = 0, sam_idx = 0, adj_used = 0.
- Sample counter:
  - Increments each clk.
  - At the edge where sam_cnt == sam_div_r ("sample wrap"): sam_cnt ← 0, sam_clk_ena ← 1.
  - sam_clk_ena ← 0 on every other edge.
- Symbol counter:
  - Advances only on sample-wrap edges.
  - On a sample wrap with sym_cnt == sym_div_r ("symbol wrap"): sym_cnt ← 0, sym_clk_ena ← 1.
  - Otherwise on a sample wrap: sym_cnt ← sym_cnt + 1, sym_clk_ena ← 0.
  - sam_idx is driven from sym_cnt.
- Configuration:
  - cfg_load copies sam_div and sym_div into the shadow and sets pend.
  - A further cfg_load while pend is set overwrites the shadow; last write wins.
  - At a symbol-wrap edge with pend set: shadow → sam_div_r/sym_div_r, pend cleared.
  - cfg_load on the same edge as a symbol wrap is captured but applied at the next symbol wrap; pend stays 1.
  - cfg_pending = pend.
- Divisor value 0 is legal:
  - sam_div_r = 0: sam_clk_ena held high continuously.
  - sym_div_r = 0: sym_clk_ena equals sam_clk_ena.
- Reset mid-operation clears all state immediately and discards any pending configuration.

## Timing
- Sample period = sam_div_r + 1 clks; symbol period = (sam_div_r + 1)(sym_div_r + 1) clks.
- Defaults: first sam_clk_ena is high in the cycle after the 4th rising edge following reset release. Thereafter it pulses every 4 clks.
- Defaults: first sym_clk_ena pulse comes after the 16th edge. Thereafter it pulses every 16 clks, aligned with every 4th sample pulse.
- Enables are registered outputs, so they are glitch-free.
- A new ratio governs the first full symbol after its symbol wrap. No runt or stretched period is produced by a reconfiguration.

## Configuration
- Macro: CLK_ENA_PHASE_ADJ_EN.
- Defined, phase_adv set:
  - sam_cnt advances by 2.
  - If sam_cnt ≥ sam_div_r − 1, the sample wraps on this edge, one clk early.
- Defined, phase_ret set: sam_cnt holds for one edge, giving one clk of delay.
- Defined, both requests on the same edge: no adjustment.
- Defined, rate limit:
  - At most one adjustment per sample period.
  - adj_used is set when an adjustment is accepted and cleared on the sample-wrap edge.
  - Requests made while adj_used = 1 are dropped.
- Defined, sam_div_r = 0: phase_adv is ignored; phase_ret suppresses one sam_clk_ena pulse.
- Not defined: phase_adv and phase_ret ports remain but are ignored, and the counters free-run.

## Test plan
- Reset release with defaults:
  - sam_clk_ena pulses after edges 4, 8, 12, 16.
  - sym_clk_ena pulses only after edge 16.
  - sam_idx sequence is 1, 2, 3, 0.
- cfg_load with sam_div = 1, sym_div = 7 mid-symbol:
  - cfg_pending = 1 until the next sym_clk_ena.
  - Then sample period is 2 clks and symbol period is 16 clks, with no runt pulse.
- cfg_load on the exact symbol-wrap edge:
  - Old ratio persists for one more symbol.
  - cfg_pending stays 1 until the following wrap.
- Reset asserted asynchronously mid-symbol with a configuration pending:
  - All outputs go to 0 immediately.
  - Default ratios resume, and cfg_pending = 0.
- With CLK_ENA_PHASE_ADJ_EN, defaults:
  - phase_ret at sam_cnt = 1 gives a 5-clk sample period.
  - phase_adv at sam_cnt = 1 gives a 3-clk period.
  - A second request in the same period has no effect.
  - Simultaneous adv and ret gives a 4-clk period.
- Without the macro: toggling phase_adv or phase_ret leaves the pulse train identical to the default run.
